// File: rtl/onewire_master_if.sv
// Status and debug bundle of the 1-Wire master: bus-drive indicator,
// received byte, sequence flags and the phase counter.
interface onewire_master_if;
  logic        en;
  logic [7:0]  master_mem;
  logic        master_init;
  logic [31:0] master_cnt;
  logic        master_cycl;
  logic        rcvd;
  logic        master_idata;

  modport master (
    output en, master_mem, master_init, master_cnt, master_cycl, rcvd, master_idata
  );

  modport slave (
    input  en, master_mem, master_init, master_cnt, master_cycl, rcvd, master_idata
  );
endinterface

// File: rtl/onewire_master.sv
// Single-drop 1-Wire master: reset pulse + presence detect, then eight read
// slots assembling one byte LSB-first on an open-drain line.
module onewire_master #(
  parameter int unsigned RESET_LOW   = 48000,
  parameter int unsigned PRES_SAMPLE = 3000,
  parameter int unsigned RESET_REC   = 48000,
  parameter int unsigned SLOT_LOW    = 600,
  parameter int unsigned SLOT_SAMPLE = 1500,
  parameter int unsigned SLOT_LEN    = 7000
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire              port,
  onewire_master_if.master bus
);
  localparam logic [31:0] C_RST_LOW_END  = 32'(RESET_LOW - 1);
  localparam logic [31:0] C_PRES_PT      = 32'(PRES_SAMPLE);
  localparam logic [31:0] C_RST_REC_END  = 32'(RESET_REC - 1);
  localparam logic [31:0] C_SLOT_LOW_END = 32'(SLOT_LOW - 1);
  localparam logic [31:0] C_SLOT_PT      = 32'(SLOT_SAMPLE);
  localparam logic [31:0] C_SLOT_END     = 32'(SLOT_LEN - 1);

  typedef enum logic [2:0] {
    ST_RST_LOW   = 3'd0,
    ST_RST_WAIT  = 3'd1,
    ST_SLOT_LOW  = 3'd2,
    ST_SLOT_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_armed;
  logic [31:0] r_cnt;
  logic [2:0]  r_bitcnt;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_en;
  logic        r_init;
  logic        r_cycl;
  logic        r_rcvd;
  logic        r_idata;
  logic [7:0]  r_mem;
  logic        w_line;
  logic        w_en_nxt;
  logic        w_cycl_nxt;
  logic        w_rcvd_nxt;
  logic        w_cnt_clr;
  logic        w_pres_pt;
  logic        w_slot_pt;
  logic        w_slot_end;
  logic        w_bit_clr;

  // Only a solid 0 reads as low; a released, x or z line counts as 1.
  assign w_line = (port === 1'b0) ? 1'b0 : 1'b1;
  assign port   = r_en ? 1'b0 : 1'bz;
  pullup u_pullup (port);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RST_LOW;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RST_LOW: begin
        if (r_armed && (r_cnt == C_RST_LOW_END)) w_state_nxt = ST_RST_WAIT;
        else                                     w_state_nxt = ST_RST_LOW;
      end
      ST_RST_WAIT: begin
        if (r_cnt == C_RST_REC_END) w_state_nxt = r_init ? ST_SLOT_LOW : ST_RST_LOW;
        else                        w_state_nxt = ST_RST_WAIT;
      end
      ST_SLOT_LOW: begin
        if (r_cnt == C_SLOT_LOW_END) w_state_nxt = ST_SLOT_WAIT;
        else                         w_state_nxt = ST_SLOT_LOW;
      end
      ST_SLOT_WAIT: begin
        if (r_cnt == C_SLOT_END) w_state_nxt = (r_bitcnt == 3'd7) ? ST_DONE : ST_SLOT_LOW;
        else                     w_state_nxt = ST_SLOT_WAIT;
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_RST_LOW;
    endcase
  end

  // The first edge after reset counts as entry into RST_LOW, so the pulse is a full RESET_LOW.
  always_comb begin
    w_en_nxt   = 1'b0;
    w_cycl_nxt = 1'b0;
    w_rcvd_nxt = 1'b0;
    case (w_state_nxt)
      ST_RST_LOW:   w_en_nxt = 1'b1;
      ST_RST_WAIT:  w_en_nxt = 1'b0;
      ST_SLOT_LOW:  begin
        w_en_nxt   = 1'b1;
        w_cycl_nxt = 1'b1;
      end
      ST_SLOT_WAIT: w_cycl_nxt = 1'b1;
      ST_DONE:      w_rcvd_nxt = 1'b1;
      default:      w_en_nxt = 1'b0;
    endcase
    w_pres_pt  = (r_state == ST_RST_WAIT)  && (r_cnt == C_PRES_PT);
    w_slot_pt  = (r_state == ST_SLOT_WAIT) && (r_cnt == C_SLOT_PT);
    w_slot_end = (r_state == ST_SLOT_WAIT) && (r_cnt == C_SLOT_END);
    w_bit_clr  = (r_state == ST_RST_WAIT)  && (w_state_nxt == ST_SLOT_LOW);
    if (!r_armed)                                                   w_cnt_clr = 1'b1;
    else if ((w_state_nxt != r_state) && (r_state != ST_SLOT_LOW)) w_cnt_clr = 1'b1;
    else                                                            w_cnt_clr = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed  <= 1'b0;
      r_cnt    <= 32'd0;
      r_bitcnt <= 3'd0;
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_en     <= 1'b0;
      r_init   <= 1'b0;
      r_cycl   <= 1'b0;
      r_rcvd   <= 1'b0;
      r_idata  <= 1'b1;
      r_mem    <= 8'd0;
    end else begin
      r_armed <= 1'b1;
      r_sync1 <= w_line;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_clr ? 32'd0 : (r_cnt + 32'd1);
      r_en    <= w_en_nxt;
      r_cycl  <= w_cycl_nxt;
      r_rcvd  <= w_rcvd_nxt;
      if (w_pres_pt && !r_sync2) r_init <= 1'b1;
      if (w_slot_pt) begin
        r_idata         <= r_sync2;
        r_mem[r_bitcnt] <= r_sync2;
      end
      if (w_bit_clr)       r_bitcnt <= 3'd0;
      else if (w_slot_end) r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

  assign bus.en           = r_en;
  assign bus.master_mem   = r_mem;
  assign bus.master_init  = r_init;
  assign bus.master_cnt   = r_cnt;
  assign bus.master_cycl  = r_cycl;
  assign bus.rcvd         = r_rcvd;
  assign bus.master_idata = r_idata;
endmodule

// File: tb/tb_onewire_master.sv
// Bench for onewire_master: a behavioural 1-Wire slave answers reset pulses and
// read slots; timings and received bytes are checked against the parameters.
module tb_onewire_master;
  localparam int RL = 480, PS = 60, RR = 480, SL = 12, SS = 30, SLEN = 140;
  localparam int PRES_MIN = 240, SLAVE_HOLD = 90;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  wire        port;
  logic       slave_low = 1'b0;
  int         slave_hold = 0, slave_lowlen = 0, slave_idx = 0;
  logic [7:0] slave_byte = 8'h00;
  logic       slave_presence = 1'b1;
  int         cyc = 0, base = 0, checks = 0, errors = 0;

  onewire_master_if bus ();

  onewire_master #(
    .RESET_LOW(RL), .PRES_SAMPLE(PS), .RESET_REC(RR),
    .SLOT_LOW(SL), .SLOT_SAMPLE(SS), .SLOT_LEN(SLEN)
  ) dut (
    .clk(clk), .reset(rst_n), .port(port), .bus(bus)
  );

  assign port = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: a long low is a reset (answer with presence), a short low is a read slot.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slave_low <= 1'b0; slave_hold <= 0; slave_lowlen <= 0; slave_idx <= 0;
    end else if (slave_hold > 0) begin
      slave_hold <= slave_hold - 1;
      if (slave_hold == 1) slave_low <= 1'b0;
    end else if (port === 1'b0) begin
      slave_lowlen <= slave_lowlen + 1;
    end else if (slave_lowlen > 0) begin
      if (slave_lowlen > PRES_MIN) begin
        if (slave_presence) begin slave_low <= 1'b1; slave_hold <= SLAVE_HOLD; end
        slave_idx <= 0;
      end else begin
        if (slave_idx < 8 && !slave_byte[slave_idx]) begin slave_low <= 1'b1; slave_hold <= SLAVE_HOLD; end
        slave_idx <= slave_idx + 1;
      end
      slave_lowlen <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.en;
      1:       return bus.master_init;
      default: return bus.rcvd;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int budget, input string tag, output int at);
    int n;
    n = 0;
    while (sig(sel) !== val && n < budget) begin @(negedge clk); n++; end
    at = cyc - base;
    if (sig(sel) !== val) check({tag, "_timeout"}, 32'(sig(sel)), 32'(val));
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; base = cyc;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_en"},    32'(bus.en), 32'd0);
    check({pfx, "_port"},  32'(port), 32'd1);
    check({pfx, "_mem"},   32'(bus.master_mem), 32'd0);
    check({pfx, "_init"},  32'(bus.master_init), 32'd0);
    check({pfx, "_cnt"},   bus.master_cnt, 32'd0);
    check({pfx, "_cycl"},  32'(bus.master_cycl), 32'd0);
    check({pfx, "_rcvd"},  32'(bus.rcvd), 32'd0);
    check({pfx, "_idata"}, 32'(bus.master_idata), 32'd1);
  endtask

  // Full sequence: reset pulse, presence, eight slots; expected byte is what the slave sends.
  task automatic run_read(input logic [7:0] data);
    int at, st, st0, prev, fall;
    slave_byte = data; slave_presence = 1'b1;
    do_reset();
    @(negedge clk);
    check("pulse_start_en", 32'(bus.en), 32'd1);
    check("pulse_start_cnt", bus.master_cnt, 32'd0);
    wait_for(0, 1'b0, RL + 8, "rst_low", at);
    check("rst_low_len", at - 1, RL);
    check("rst_wait_cnt", bus.master_cnt, 32'd0);
    wait_for(1, 1'b1, PS + 8, "presence", at);
    check("presence_time", at, RL + PS + 2);
    check("cycl_idle", 32'(bus.master_cycl), 32'd0);
    wait_for(0, 1'b1, RR, "slot0", st);
    check("slot0_start", st, RL + RR + 1);
    st0 = st;
    for (int s = 0; s < 8; s++) begin
      if (s > 0) begin
        prev = st;
        wait_for(0, 1'b1, SLEN + 8, "slot_rise", st);
        check("slot_period", st - prev, SLEN);
        check("slot_bit", 32'(bus.master_idata), 32'(data[s-1]));
      end
      check("slot_cnt0", bus.master_cnt, 32'd0);
      check("slot_cycl", 32'(bus.master_cycl), 32'd1);
      wait_for(0, 1'b0, SL + 8, "slot_fall", fall);
      check("slot_low_len", fall - st, SL);
      check("slot_cnt_run", bus.master_cnt, 32'(SL));
    end
    wait_for(2, 1'b1, SLEN + 8, "rcvd", at);
    check("done_time", at - st0, 8 * SLEN);
    check("done_mem", 32'(bus.master_mem), 32'(data));
    check("done_idata", 32'(bus.master_idata), 32'(data[7]));
    check("done_cycl", 32'(bus.master_cycl), 32'd0);
    check("done_en", 32'(bus.en), 32'd0);
    check("done_init", 32'(bus.master_init), 32'd1);
  endtask

  initial begin
    int at, st, fall;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");

    run_read(8'hAA);
    run_read(8'hFF);
    for (int r = 0; r < 3; r++) run_read(8'($urandom));

    // Silent slave: no presence, master retries with a fresh pulse.
    slave_presence = 1'b0;
    do_reset();
    @(negedge clk);
    wait_for(0, 1'b0, RL + 8, "np_low", at);
    check("np_low_len", at - 1, RL);
    wait_for(0, 1'b1, RR + 8, "np_retry", at);
    check("np_retry_start", at, RL + RR + 1);
    check("np_init", 32'(bus.master_init), 32'd0);
    check("np_cycl", 32'(bus.master_cycl), 32'd0);
    check("np_cnt", bus.master_cnt, 32'd0);
    wait_for(0, 1'b0, RL + 8, "np_low2", fall);
    check("np_low2_len", fall - at, RL);
    check("np_rcvd", 32'(bus.rcvd), 32'd0);

    // Reset asserted in the middle of slot 3.
    slave_byte = 8'($urandom); slave_presence = 1'b1;
    do_reset();
    @(negedge clk);
    wait_for(0, 1'b0, RL + 8, "mr_low", at);
    for (int s = 0; s < 3; s++) begin
      wait_for(0, 1'b1, RR + SLEN + 8, "mr_slot", st);
      if (s < 2) wait_for(0, 1'b0, SL + 8, "mr_fall", fall);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mr");
    @(negedge clk);
    rst_n = 1'b1; base = cyc;
    @(negedge clk);
    check("mr_restart_en", 32'(bus.en), 32'd1);
    wait_for(0, 1'b0, RL + 8, "mr_low2", at);
    check("mr_pulse_len", at - 1, RL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
